// File: rtl/debounce_pkg.sv
// Shared constants for the switch debouncer: FSM state encodings and a clog2 helper.
package debounce_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ZERO  = 2'b00;
    localparam logic [STATE_W-1:0] WAIT1 = 2'b01;
    localparam logic [STATE_W-1:0] ONE   = 2'b10;
    localparam logic [STATE_W-1:0] WAIT0 = 2'b11;

    // Smallest width able to index 'value' distinct items.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-stage flop chain bringing one asynchronous bit into the clk domain.
// All stages reset asynchronously to 0.
module bit_synchronizer #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("bit_synchronizer: SYNC_STAGES must be >= 2");
    end

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/tick_debouncer.sv
// Tick-paced switch debouncer: synchronizer, 4-state FSM and stability down-counter.
// Define DB_FALL_TICK_EN to add the db_fall_tick output and its register.
module tick_debouncer #(
    parameter int unsigned STABLE_TICKS = 3,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sample_tick,
    input  logic sw,
    output logic db_level,
    output logic db_tick
`ifdef DB_FALL_TICK_EN
    ,
    output logic db_fall_tick
`endif
);

    import debounce_pkg::*;

    if (STABLE_TICKS < 1) begin : g_bad_ticks
        $error("tick_debouncer: STABLE_TICKS must be >= 1");
    end

    localparam int unsigned CNT_W = (STABLE_TICKS < 1) ? 1 : clog2(STABLE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STABLE_TICKS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic               sw_s;
    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               db_tick_q;

    bit_synchronizer #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (sw),
        .q    (sw_s)
    );

    // Loss of the candidate level aborts before a coincident tick is considered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ZERO: begin
                if (sw_s) begin
                    state_d = WAIT1;
                    cnt_d   = CNT_LOAD;
                end
            end
            WAIT1: begin
                if (!sw_s) begin
                    state_d = ZERO;
                end else if (sample_tick) begin
                    if (cnt_q == CNT_ONE) begin
                        state_d = ONE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            ONE: begin
                if (!sw_s) begin
                    state_d = WAIT0;
                    cnt_d   = CNT_LOAD;
                end
            end
            WAIT0: begin
                if (sw_s) begin
                    state_d = ONE;
                end else if (sample_tick) begin
                    if (cnt_q == CNT_ONE) begin
                        state_d = ZERO;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = ZERO;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ZERO;
            cnt_q     <= '0;
            db_tick_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            db_tick_q <= (state_q == WAIT1) && (state_d == ONE);
        end
    end

    assign db_level = (state_q == ONE) || (state_q == WAIT0);
    assign db_tick  = db_tick_q;

`ifdef DB_FALL_TICK_EN
    logic db_fall_tick_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_fall_tick_q <= 1'b0;
        end else begin
            db_fall_tick_q <= (state_q == WAIT0) && (state_d == ZERO);
        end
    end

    assign db_fall_tick = db_fall_tick_q;
`endif

endmodule

// File: doc/tick_debouncer.md
Name: tick_debouncer

Overview:
Debounces one raw mechanical switch or button input. A periodic one-cycle sample enable paces the debouncer, normally the max_tick of the free-running binary counter (N=19 at 50 MHz gives about 10 ms). The block sits directly downstream of that counter and upstream of user logic that needs a clean level plus single-cycle edge pulses. It contains an input synchronizer, a 4-state FSM and a stability down-counter.

Parameters:
STABLE_TICKS, 3, number of consecutive sample_ticks the synchronized input must hold a new level before db_level changes. Must be >= 1; 0 is an elaboration error.
SYNC_STAGES, 2, number of flip-flop stages in the input synchronizer. Must be >= 2.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
sample_tick  in  1  one-cycle sample enable, normally the counter's max_tick; may be tied high
sw  in  1  raw asynchronous switch input
db_level  out  1  debounced level
db_tick  out  1  one-cycle pulse on a debounced 0->1 transition
db_fall_tick  out  1  one-cycle pulse on a debounced 1->0 transition; present only with DB_FALL_TICK_EN

Behaviour:
Reset state:
- reset is asynchronous, active-high; clock is clk.
- On reset, all synchronizer flops = 0, state = ZERO, cnt = 0, db_level = 0, db_tick = 0, db_fall_tick = 0.
- Reset asserted mid-operation aborts any pending qualification.

Synchronizer and counter:
- sw passes through SYNC_STAGES flops; the last stage output is sw_s. The FSM sees only sw_s.
- cnt width = clog2(STABLE_TICKS+1).

FSM (registered state):
- ZERO: if sw_s=1, go to WAIT1 and load cnt=STABLE_TICKS. Entry does not wait for a tick.
- WAIT1:
  - if sw_s=0, go to ZERO. Abort has priority over a coincident sample_tick.
  - else on sample_tick: if cnt==1, go to ONE; otherwise cnt-1.
- ONE: if sw_s=0, go to WAIT0 and load cnt=STABLE_TICKS.
- WAIT0: mirror of WAIT1.
  - sw_s=1 returns to ONE.
  - on sample_tick with cnt==1, go to ZERO.

Outputs:
- db_level = 1 in ONE and WAIT0, 0 otherwise. It is decoded from registered state, so it is glitch-free.
- db_tick is registered and high for exactly the first cycle db_level=1 after a WAIT1->ONE transition.
- A WAIT0->ONE abort produces no db_tick.

Latency and boundary cases:
- Latency from a stable sw edge is SYNC_STAGES + 1 cycles, plus the time to collect STABLE_TICKS sample_ticks.
- With sample_tick tied high, STABLE_TICKS=3 and SYNC_STAGES=2, db_level rises 6 cycles after sw rises.
- sample_tick asserted on the entry cycle into WAIT1/WAIT0 is not counted. Counting starts the cycle after entry.
- STABLE_TICKS=1: the first sample_tick after entry completes qualification.
- cnt never wraps. It is reloaded on every WAIT entry and held in ZERO and ONE.

Optional Feature:
DB_FALL_TICK_EN
- Defined: db_fall_tick port exists. It is registered and high for exactly the first cycle db_level=0 after a WAIT0->ZERO transition. Its reset value is 0.
- Undefined: the port and its register are absent. All other behaviour is identical.

Decomposition:
- Package debounce_pkg holds:
  - the state encodings ZERO=2'b00, WAIT1=2'b01, ONE=2'b10, WAIT0=2'b11;
  - the state width constant;
  - a clog2 helper function.
- One sub-module, bit_synchronizer: a parameterised SYNC_STAGES flop chain with asynchronous reset to 0. It is reusable by other input blocks.
- The FSM, counter and output registers stay in tick_debouncer.

Test Plan:
1. Assert reset for 3 cycles with sw=1 -> db_level=0, db_tick=0 throughout. After release, db_level rises only after the full qualification (6 cycles with tick tied high, STABLE_TICKS=3).
2. Bench settings: STABLE_TICKS=3, SYNC_STAGES=2, sample_tick every 8 cycles. Clean press, sw 0->1 held -> db_level rises on the edge sampling the 3rd sample_tick after WAIT1 entry. Exactly one db_tick, coincident with db_level's first high cycle.
3. Bounce: sw toggles every 5 cycles for 40 cycles, then holds 1 -> no db_tick and db_level=0 during the bounce. Exactly one db_tick, 3 ticks after bouncing stops.
4. Release: sw 1->0 held -> db_level falls after 3 ticks and db_tick stays 0. With DB_FALL_TICK_EN, exactly one db_fall_tick, coincident with db_level's first low cycle.
5. Abort versus tick: in WAIT1 with cnt==1, drop sw_s on the same cycle as sample_tick -> state=ZERO and no db_tick.
6. Reset in WAIT1 after 2 ticks counted, with sw held 1 -> outputs 0 immediately. After reset release, a full 3 new ticks are required before db_level=1.
